icache_assoc: RTL

- Parametrised set-associative instruction cache, successor to the single-word direct-mapped icache.
- Sits between the IFU fetch port and the instruction memory/bus.
- Generalised in ways, sets and line size.
- Adds multi-beat line refill FSM, replacement policy, request/ready handshake and flush.

---
 rtl/icache_assoc.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-beat line refill, round-robin replacement and flush; ICACHE_PERF_EN adds hit/miss counters.
// Latency: hit responds the cycle after acceptance; miss responds 2 + request-wait + beat cycles after acceptance.
// Backpressure: one request in flight; req_ready is high only in IDLE, and mem_req_valid/mem_req_addr hold until mem_req_ready.
module icache_assoc #(
   parameter int WAYS       = 2,
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [29:0] req_addr,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_hit,
   input  logic        flush,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [29:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic [31:0] perf_hits,
   output logic [31:0] perf_misses
);
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 30 - IDX_W - OFF_W;
   localparam int BEAT_W = (OFF_W > 0) ? OFF_W : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESP} state_t;

   state_t                    state_q, state_d;
   logic [WAYS-1:0][SETS-1:0] valid_q;
   logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
   logic [31:0]               data_q [WAYS][SETS][LINE_WORDS];
   logic [WAY_W-1:0]          rr_q   [SETS];
   logic [29:0]               addr_q;
   logic [WAY_W-1:0]          victim_q, victim;
   logic [BEAT_W-1:0]         beat_q;
   logic [31:0]               word_q, last_q, hit_word;
   logic                      flush_pend_q, flush_all, accept;
   logic [WAYS-1:0]           hit_vec;
   logic                      hit, any_inv, last_beat;
   logic [IDX_W-1:0]          idx_r;
   logic [TAG_W-1:0]          tag_r;
   logic [BEAT_W-1:0]         off_r;

   assign idx_r        = IDX_W'(addr_q >> OFF_W);
   assign tag_r        = TAG_W'(addr_q >> (OFF_W + IDX_W));
   assign off_r        = BEAT_W'(addr_q & 30'(LINE_WORDS - 1));
   assign mem_req_addr = addr_q & ~30'(LINE_WORDS - 1);
   assign last_beat    = (beat_q == BEAT_W'(LINE_WORDS - 1));

   // Tag compare across ways; victim is the lowest invalid way, else the set's round-robin pointer.
   always_comb begin
      hit_vec  = '0;
      hit_word = '0;
      any_inv  = 1'b0;
      victim   = rr_q[idx_r];
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid_q[w][idx_r] && (tag_q[w][idx_r] == tag_r);
         if (hit_vec[w]) hit_word = data_q[w][idx_r][off_r];
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][idx_r]) begin
            victim  = WAY_W'(w);
            any_inv = 1'b1;
         end
      end
   end

   assign hit = (hit_vec != '0) && ((hit_vec & (hit_vec - WAYS'(1))) == '0);

   always_comb begin
      state_d       = state_q;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_hit      = 1'b0;
      resp_data     = last_q;
      mem_req_valid = 1'b0;
      flush_all     = 1'b0;
      accept        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush || flush_pend_q) begin
               flush_all = 1'b1;
            end else begin
               req_ready = 1'b1;
               if (req_valid) begin
                  accept  = 1'b1;
                  state_d = S_LOOKUP;
               end
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               resp_valid = 1'b1;
               resp_hit   = 1'b1;
               resp_data  = hit_word;
               state_d    = S_IDLE;
            end else begin
               state_d = S_MISS_REQ;
            end
         end
         S_MISS_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = S_REFILL;
         end
         S_REFILL: begin
            if (mem_resp_valid && last_beat) state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_data  = word_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         victim_q     <= '0;
         beat_q       <= '0;
         word_q       <= '0;
         last_q       <= '0;
         flush_pend_q <= 1'b0;
         valid_q      <= '0;
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) addr_q <= req_addr;
         if (resp_valid) last_q <= resp_data;
         if (flush_all) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
         end else if (flush && state_q != S_IDLE) begin
            flush_pend_q <= 1'b1;
         end
         case (state_q)
            S_LOOKUP: begin
               if (!hit) begin
                  victim_q <= victim;
                  if (!any_inv) rr_q[idx_r] <= WAY_W'((32'(rr_q[idx_r]) + 1) % WAYS);
               end
            end
            S_MISS_REQ: begin
               if (mem_req_ready) begin
                  beat_q                   <= '0;
                  valid_q[victim_q][idx_r] <= 1'b0;
               end
            end
            S_REFILL: begin
               if (mem_resp_valid) begin
                  beat_q <= beat_q + BEAT_W'(1);
                  if (beat_q == off_r) word_q <= mem_resp_data;
                  if (last_beat) valid_q[victim_q][idx_r] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Line storage carries no reset; validity alone decides whether contents are used.
   always_ff @(posedge clock) begin
      if (!reset && state_q == S_REFILL && mem_resp_valid) begin
         data_q[victim_q][idx_r][beat_q] <= mem_resp_data;
         if (last_beat) tag_q[victim_q][idx_r] <= tag_r;
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hits_q, misses_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else if (state_q == S_LOOKUP) begin
         if (hit) hits_q   <= hits_q + 32'd1;
         else     misses_q <= misses_q + 32'd1;
      end
   end

   assign perf_hits   = hits_q;
   assign perf_misses = misses_q;
`else
   assign perf_hits   = '0;
   assign perf_misses = '0;
`endif
endmodule
